// File: rtl/alu_muldiv.sv
// Sequential ALU: single-cycle logic/arith ops plus optional radix-2 multiply and restoring divide.
// Build macro ALU_MULDIV_EN enables MUL/MULHU/DIVU/REMU; without it opcodes 10-13 return zero in one cycle.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic [WIDTH-1:0] port_o,
    output logic             busy,
    output logic             done,
    output logic             flag_negative,
    output logic             flag_zero,
    output logic             flag_overflow,
    output logic             flag_divzero
);

    localparam int unsigned W = WIDTH;

    localparam logic [3:0] OP_SLL   = 4'd0;
    localparam logic [3:0] OP_SRL   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;
    localparam int unsigned CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
`else
    typedef enum logic [0:0] {S_IDLE, S_DONE} state_e;
`endif

    state_e         state_q, state_d;
    logic [W-1:0]   res_q, res_d;
    logic           neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;
    logic           busy_q, busy_d, done_q, done_d;

    logic [W-1:0]   alu_res_c;
    logic           alu_ovf_c;
    logic [W-1:0]   sum_c, diff_c;

    logic           load_c, ld_ovf_c, ld_dz_c;
    logic [W-1:0]   ld_val_c;

`ifdef ALU_MULDIV_EN
    // acc holds {hi,lo} product during MUL and {remainder,quotient} during DIV
    logic           sel_hi_q, sel_hi_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [W-1:0]   mul_addend_c;
    logic [W:0]     mul_sum_c;
    logic [2*W-1:0] mul_next_c;
    logic [W:0]     div_sh_c, div_diff_c;
    logic [2*W-1:0] div_next_c;

    always_comb begin
        mul_addend_c = acc_q[0] ? opb_q : '0;
        mul_sum_c    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend_c};
        mul_next_c   = {mul_sum_c, acc_q[W-1:1]};
        div_sh_c     = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff_c   = div_sh_c - {1'b0, opb_q};
        div_next_c   = div_diff_c[W] ? {div_sh_c[W-1:0], acc_q[W-2:0], 1'b0}
                                     : {div_diff_c[W-1:0], acc_q[W-2:0], 1'b1};
    end
`endif

    // Single-cycle result path, evaluated on the live operands at the start edge
    always_comb begin
        sum_c     = port_a + port_b;
        diff_c    = port_a - port_b;
        alu_res_c = '0;
        alu_ovf_c = 1'b0;
        case (aluop)
            OP_SLL:  alu_res_c = port_a << port_b[SHW-1:0];
            OP_SRL:  alu_res_c = port_a >> port_b[SHW-1:0];
            OP_ADD: begin
                alu_res_c = sum_c;
                alu_ovf_c = (port_a[W-1] == port_b[W-1]) && (sum_c[W-1] != port_a[W-1]);
            end
            OP_SUB: begin
                alu_res_c = diff_c;
                alu_ovf_c = (port_a[W-1] != port_b[W-1]) && (diff_c[W-1] != port_a[W-1]);
            end
            OP_AND:  alu_res_c = port_a & port_b;
            OP_OR:   alu_res_c = port_a | port_b;
            OP_XOR:  alu_res_c = port_a ^ port_b;
            OP_NOR:  alu_res_c = ~(port_a | port_b);
            OP_SLT:  alu_res_c = W'($signed(port_a) < $signed(port_b));
            OP_SLTU: alu_res_c = W'(port_a < port_b);
            default: alu_res_c = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
            sel_hi_q <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef ALU_MULDIV_EN
            sel_hi_q <= sel_hi_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        load_c   = 1'b0;
        ld_val_c = '0;
        ld_ovf_c = 1'b0;
        ld_dz_c  = 1'b0;
`ifdef ALU_MULDIV_EN
        sel_hi_d = sel_hi_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
`ifdef ALU_MULDIV_EN
                    if (aluop == OP_MUL || aluop == OP_MULHU) begin
                        state_d  = S_MUL;
                        sel_hi_d = (aluop == OP_MULHU);
                        opb_d    = port_a;
                        acc_d    = {{W{1'b0}}, port_b};
                        cnt_d    = '0;
                    end else if ((aluop == OP_DIVU || aluop == OP_REMU) && port_b == '0) begin
                        state_d  = S_DONE;
                        load_c   = 1'b1;
                        ld_val_c = (aluop == OP_DIVU) ? '1 : port_a;
                        ld_dz_c  = 1'b1;
                    end else if (aluop == OP_DIVU || aluop == OP_REMU) begin
                        state_d  = S_DIV;
                        sel_hi_d = (aluop == OP_REMU);
                        opb_d    = port_b;
                        acc_d    = {{W{1'b0}}, port_a};
                        cnt_d    = '0;
                    end else
`endif
                    begin
                        state_d  = S_DONE;
                        load_c   = 1'b1;
                        ld_val_c = alu_res_c;
                        ld_ovf_c = alu_ovf_c;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            S_MUL: begin
                acc_d = mul_next_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) begin
                    state_d  = S_DONE;
                    load_c   = 1'b1;
                    ld_val_c = sel_hi_q ? mul_next_c[2*W-1:W] : mul_next_c[W-1:0];
                end
            end
            S_DIV: begin
                acc_d = div_next_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W-1)) begin
                    state_d  = S_DONE;
                    load_c   = 1'b1;
                    ld_val_c = sel_hi_q ? div_next_c[2*W-1:W] : div_next_c[W-1:0];
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (load_c) begin
            res_d  = ld_val_c;
            neg_d  = ld_val_c[W-1];
            zero_d = (ld_val_c == '0);
            ovf_d  = ld_ovf_c;
            dz_d   = ld_dz_c;
        end

        done_d = (state_d == S_DONE);
`ifdef ALU_MULDIV_EN
        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
`else
        busy_d = 1'b0;
`endif
    end

    assign port_o        = res_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign flag_negative = neg_q;
    assign flag_zero     = zero_q;
    assign flag_overflow = ovf_q;
    assign flag_divzero  = dz_q;

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width derived from WIDTH.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request pulse; operands and aluop sampled when start=1 and busy=0.
REQ-006 SHALL have port aluop  input  4  operation code (see REQ-011).
REQ-007 SHALL have ports port_a, port_b  input  WIDTH  operands.
REQ-008 SHALL have port port_o  output  WIDTH  registered result.
REQ-009 SHALL have ports busy, done  output  1  busy: operation in flight; done: one-cycle pulse when port_o/flags become valid.
REQ-010 SHALL have ports flag_negative, flag_zero, flag_overflow, flag_divzero  output  1  registered status flags.

Function
REQ-011 Encoding SHALL be 0 SLL, 1 SRL, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT, 9 SLTU, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU; 14-15 give port_o=0.
REQ-012 FSM states SHALL be IDLE, MUL, DIV, DONE; busy=1 in MUL and DIV only.
REQ-013 Single-cycle ops (0-9, 14-15): IDLE --start--> DONE; result and flags latched at the start edge; done=1 in the following cycle; latency 1.
REQ-014 MUL/MULHU: IDLE->MUL, radix-2 shift-add over an unsigned 2*WIDTH product, one bit per cycle, exactly WIDTH cycles, then DONE; latency WIDTH+1.
REQ-015 DIVU/REMU: IDLE->DIV, restoring divide, one quotient bit per cycle, WIDTH cycles, then DONE; latency WIDTH+1.
REQ-016 Divide by zero SHALL skip iteration (IDLE->DONE, latency 1): DIVU gives all-ones, REMU gives port_a, flag_divzero=1.
REQ-017 DONE SHALL last exactly one cycle and return to IDLE; start is accepted in the same cycle as DONE (back-to-back).
REQ-018 start while busy=1 SHALL be ignored; operands are captured internally and later changes on port_a/port_b do not affect the op in flight.
REQ-019 Shifts SHALL use port_b[SHW-1:0] only and shift logically (zero fill).
REQ-020 flag_overflow SHALL be set for ADD on equal operand signs with a differing result sign, and for SUB on differing operand signs with result sign differing from port_a; 0 for all other ops.
REQ-021 flag_negative = port_o[WIDTH-1] and flag_zero = (port_o==0), both registered with port_o; flag_divzero=0 except REQ-016.
REQ-022 SLT/SLTU SHALL give 1 or 0 in bit 0, upper bits zero; SLT signed, SLTU unsigned.
REQ-023 port_o and flags SHALL hold their last value until the next completion; they are not updated during MUL/DIV.

Reset
REQ-024 nRST=0 SHALL immediately force state IDLE, port_o=0, all flags 0, busy=0, done=0, internal operand/accumulator registers 0.
REQ-025 Reset asserted mid-MUL/DIV SHALL abort the operation with no done pulse; the first start after release is accepted normally.

Configuration
REQ-026 Macro ALU_MULDIV_EN defined: MUL, MULHU, DIVU, REMU behave per REQ-014 to REQ-016.
REQ-027 ALU_MULDIV_EN undefined: multiplier/divider logic and MUL/DIV states SHALL be absent; opcodes 10-13 behave as 14-15 (port_o=0, latency 1, flag_divzero=0).

Verification
REQ-028 WIDTH=32, ADD 0x7FFFFFFF+0x00000001 -> done next cycle, port_o=0x80000000, flag_overflow=1, flag_negative=1.
REQ-029 WIDTH=32, MULHU 0xFFFFFFFF*0xFFFFFFFF -> busy 32 cycles, done at cycle 33, port_o=0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-030 WIDTH=32, DIVU 100/7 -> 14 (0xE) at cycle 33; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF, flag_divzero=1, latency 1.
REQ-031 WIDTH=8, SLL 0x01 by port_b=0x0B -> port_o=0x08 (only 3 low bits used); SLT 0x80 vs 0x01 -> 1, SLTU -> 0.
REQ-032 Start DIVU, drop nRST at cycle 10 -> outputs 0 immediately, no done; after release, AND 0xF0&0x3C -> 0x30 in 1 cycle; second start during busy ignored.
